// File: rtl/ex_div_seq.sv
// ============================================================================
// Module      : ex_div_seq
// Description : Multi-cycle restoring divider for the EX stage. Sign-corrected
//               quotient/remainder, start/done handshake, pipeline stall and
//               cancel (flush) support. One quotient bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;         // latched dividend
    logic [WIDTH-1:0] b_q, b_d;         // latched divisor
    logic             sgn_q, sgn_d;     // latched is_signed
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;     // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dmag_q, dmag_d;   // divisor magnitude
    logic [CW-1:0]    cnt_q, cnt_d;     // iterations remaining
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] quot_q, quot_d;   // registered quotient output
    logic [WIDTH-1:0] remo_q, remo_d;   // registered remainder output
    logic             dbz_q, dbz_d;

    // Two's-complement negation modulo 2^WIDTH; the most negative value maps to itself.
    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_upper;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;

    assign w_a_mag = (sgn_q && a_q[WIDTH-1]) ? neg(a_q) : a_q;
    assign w_b_mag = (sgn_q && b_q[WIDTH-1]) ? neg(b_q) : b_q;

    // Upper half after the 1-bit left shift. Since the partial remainder is
    // always below the divisor magnitude, the (WIDTH+1)-bit difference never
    // wraps, so its MSB is a clean borrow and doubles as the >= compare.
    assign w_upper = {rem_q, quo_q[WIDTH-1]};
    assign w_sub   = w_upper - {1'b0, dmag_q};
    assign w_ge    = ~w_sub[WIDTH];

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dmag_q  <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dmag_q  <= dmag_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and datapath update; cancel aborts PREP/ITER/FIX without touching outputs.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dmag_d  = dmag_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    a_d     = dividend;
                    b_d     = divisor;
                    sgn_d   = is_signed;
                    state_d = S_PREP;
                end
            end

            S_PREP: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d  = w_a_mag;
                    dmag_d = w_b_mag;
                    qneg_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    rneg_d = sgn_q & a_q[WIDTH-1];
                    rem_d  = '0;
                    cnt_d  = CW'(WIDTH);
                    if (b_q == '0) begin
                        quot_d  = '1;
                        remo_d  = a_q;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ITER;
                    end
                end
            end

            S_ITER: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (w_ge) begin
                        rem_d = w_sub[WIDTH-1:0];
                    end else begin
                        rem_d = w_upper[WIDTH-1:0];
                    end
                    quo_d = {quo_q[WIDTH-2:0], w_ge};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    quot_d  = qneg_q ? neg(quo_q) : quo_q;
                    remo_d  = rneg_q ? neg(rem_q) : rem_q;
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign stall       = busy & ~done;
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_div_seq.sv
// ============================================================================
// Module      : tb_ex_div_seq
// Description : Scoreboard bench for ex_div_seq: directed cases plus random
//               operands against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic         cancel = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, stall, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    ex_div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .cancel      (cancel),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_e;
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic; C-style / and % truncate toward zero.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        exp_t   e;
        longint x, y;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            if (s) begin
                x = longint'($signed(a));
                y = longint'($signed(b));
            end else begin
                x = longint'({32'd0, a});
                y = longint'({32'd0, b});
            end
            e.q = W'(x / y);
            e.r = W'(x % y);
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 q=%0h r=%0h required no done", quotient, remainder);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", {31'd0, quotient, remainder, div_by_zero}, {31'd0, mon_e.q, mon_e.r, mon_e.z});
            end
        end
    end

    // Issue one divide, check done latency and stall profile; returns in the first IDLE cycle.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        exp_t e;
        int   lat;
        int   exp_lat;
        bit   stall_ok;
        e = model(a, b, s);
        exp_lat = (b == '0) ? 2 : 35;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b; is_signed = s;
        sb_q.push_back(e);
        last_e = e;
        @(posedge clk);
        #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
        lat = 0;
        stall_ok = 1'b1;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                if (stall || !busy) stall_ok = 1'b0;
            end else if (!stall || !busy) begin
                stall_ok = 1'b0;
            end
        end
        check("latency", 96'(lat), 96'(exp_lat));
        check("stall_profile", {95'd0, stall_ok}, 96'd1);
        @(posedge clk);
        #1;
        check("idle_after_done", {94'd0, busy, done}, 96'd0);
    endtask

    logic [W-1:0] ra, rb;
    int           sel;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_state", {29'd0, busy, stall, done, quotient, remainder, div_by_zero}, 96'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        last_e = '0;

        // Directed cases
        run_div(32'hFFFFFFF9, 32'h00000002, 1'b1);
        run_div(32'hFFFFFFFF, 32'h00000010, 1'b0);
        run_div(32'hFFFFFFFF, 32'h00000010, 1'b1);
        run_div(32'h00000005, 32'h00000000, 1'b1);
        run_div(32'h00000009, 32'h00000004, 1'b1);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1);
        run_div(32'h80000000, 32'h00000002, 1'b1);
        run_div(32'hFFFFFFFF, 32'h00000001, 1'b0);

        // Start with cancel in the same cycle: cancel wins
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_idle", {95'd0, busy}, 96'd0);

        // Cancel mid-operation; the second start at t+5 must be ignored
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = (n == 5);
            if (n == 5) begin
                dividend = 32'd1; divisor = 32'd1;
            end
            cancel = (n == 10);
        end
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_busy", {95'd0, busy}, 96'd0);
        check("cancel_hold", {31'd0, quotient, remainder, div_by_zero}, {31'd0, last_e.q, last_e.r, last_e.z});
        repeat (40) @(posedge clk);
        #1;
        check("cancel_still_idle", {95'd0, busy}, 96'd0);
        run_div(32'd100, 32'd7, 1'b0);

        // Asynchronous reset mid-ITER, asserted between clock edges
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {29'd0, busy, stall, done, quotient, remainder, div_by_zero}, 96'd0);
        last_e = '0;
        @(negedge clk) rst_n = 1'b1;
        run_div(32'd20, 32'd3, 1'b0);

        // Random operands, back-to-back issue
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       rb = '0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFFFFFF;
                3:       rb = $urandom_range(1, 15);
                4:       rb = ~W'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 7) == 0) ra = ra >> $urandom_range(8, 31);
            run_div(ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 96'(sb_q.size()), 96'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/ex_div_seq.md
Name: ex_div_seq

Overview:
- Multi-cycle 32-bit integer divider sequencer for the EX stage of the pipeline CPU.
- Takes operand magnitudes with the team's two's-complement negation rule. 0x80000000 negates to itself, and negation is modulo 2^WIDTH.
- Runs a restoring shift-subtract loop at one bit per cycle, then applies sign correction.
- Raises stall to freeze IF/ID/EX while running, and returns quotient and remainder through a start/done handshake.

Parameters:
- WIDTH, 32, operand and result width. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = signed division, 0 = unsigned; sampled with start.
- cancel  input  1  pipeline flush; aborts the operation in progress.
- dividend  input  WIDTH  dividend; sampled with start.
- divisor  input  WIDTH  divisor; sampled with start.
- busy  output  1  high in every state except IDLE.
- stall  output  1  equals busy AND NOT done. Combinational from the state register.
- done  output  1  single-cycle pulse; results are valid in that cycle.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag for the last completed operation.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. busy, stall, done, quotient, remainder and div_by_zero are all 0. The internal iteration counter and working registers are cleared. Reset takes effect immediately, including mid-operation.
- FSM states: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - On start=1 and cancel=0: latch the operands and is_signed, then go to PREP.
  - start while not in IDLE is ignored.
  - If cancel=1 in the same cycle as start, cancel wins and the state stays IDLE.
- PREP:
  - Form magnitudes. When is_signed=1 and the operand MSB is 1, the magnitude is the negated operand; otherwise the raw value.
  - Record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend), both forced to 0 when unsigned.
  - Clear the partial remainder and load counter = WIDTH.
  - If divisor==0: go to DONE directly with quotient=all-ones, remainder=original dividend and div_by_zero=1. Otherwise go to ITER.
- ITER:
  - Each cycle: shift {partial remainder, dividend magnitude} left by 1.
  - If the upper half is >= the divisor magnitude, subtract the divisor magnitude and set quotient bit 0 to 1.
  - Decrement the counter. After the WIDTH-th iteration, go to FIX.
  - Use a (WIDTH+1)-bit compare/subtract so 0xFFFFFFFF/1 is correct.
- FIX:
  - Quotient = q_neg ? negate(q_mag) : q_mag.
  - Remainder = r_neg ? negate(r_mag) : r_mag.
  - Write both to the output registers with div_by_zero=0, then go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Outputs hold their values until the next completed operation.
- Latency, with start accepted on edge t:
  - Normal operation: PREP in cycle t+1, ITER in t+2..t+(WIDTH+1), FIX in t+(WIDTH+2), DONE in t+(WIDTH+3), which is t+35 for WIDTH=32. IDLE again at t+36.
  - Divide-by-zero: done at t+2.
  - Back-to-back: a new start is accepted in the first IDLE cycle after DONE.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0. This follows from the negation rule and needs no special case.
- Cancel:
  - cancel=1 in PREP, ITER or FIX forces IDLE on the next edge, with no done pulse.
  - quotient, remainder and div_by_zero keep their previous values.
  - cancel in DONE does not suppress that cycle's done pulse.
- Sign rules: quotient truncates toward zero, and a non-zero remainder takes the sign of the dividend.

Test Plan:
1. Signed -7 / 2, dividend 0xFFFFFFF9 and divisor 0x00000002 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Done pulses exactly at t+35, and stall is high from t+1 through t+34.
2. Unsigned 0xFFFFFFFF / 0x00000010 -> quotient=0x0FFFFFFF, remainder=0x0000000F, div_by_zero=0. A signed run of the same operands gives quotient=0, remainder=0xFFFFFFFF.
3. Signed 5 / 0 -> done at t+2 with quotient=0xFFFFFFFF, remainder=0x00000005, div_by_zero=1. The next valid divide, 9/4, clears the flag and gives quotient=2, remainder=1.
4. Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Signed 0x80000000 / 0x00000002 -> quotient=0xC0000000, remainder=0.
5. Start 100/7; pulse start again at t+5, which is ignored; raise cancel at t+10 -> busy=0 at t+11 and no done pulse, outputs hold the prior result. A fresh 100/7 then gives quotient=14, remainder=2.
6. Drive rst_n=0 asynchronously mid-ITER, between clock edges -> busy, stall, done and all outputs are 0 immediately. After release, start 20/3 -> quotient=6, remainder=2 at t+35.
